// File: rtl/spirw_pkg.sv
// Shared definitions for the SPI register read/write master and slave.
// Command codes, header layout and FSM state encodings.
package spirw_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    localparam logic [2:0] HDR_WR_BYTES = 3'd5;
    localparam logic [2:0] HDR_RD_BYTES = 3'd6;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_WAIT_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    // Header byte by position: command, address MSB first, dummy.
    function automatic logic [7:0] hdr_byte(
        input logic        rd,
        input logic [31:0] addr,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = rd ? CMD_READ : CMD_WRITE;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            default: b = DUMMY_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spirw_master.sv
// SPI mode-0 master issuing command/address/data frames.
// Write bytes stream in on a valid/ready pair; read bytes leave as strobes.
module spirw_master
    import spirw_pkg::*;
#(
    parameter int C_CLK_DIV  = 2,
    parameter int C_LEN_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_rd,
    input  logic [31:0]           i_addr,
    input  logic [C_LEN_BITS-1:0] i_len,
    input  logic [7:0]            i_wdata,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [7:0]            o_rdata,
    output logic                  o_rvalid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_csn,
    output logic                  o_sclk,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam logic [7:0]            DIV_LAST = 8'(C_CLK_DIV - 1);
    localparam logic [C_LEN_BITS-1:0] LEN_ONE  = 1;

    logic [2:0]            state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [2:0]            bit_q, bit_d;
    logic [2:0]            idx_q, idx_d;
    logic                  data_q, data_d;
    logic [C_LEN_BITS-1:0] rem_q, rem_d;
    logic                  rd_q, rd_d;
    logic [31:0]           addr_q, addr_d;
    logic [7:0]            sh_q, sh_d;
    logic [7:0]            rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;

    logic                  div_last;
    logic [7:0]            div_inc;
    logic [2:0]            nxt_idx;
    logic [2:0]            hdr_len;
    logic [7:0]            rx_smp;
    logic                  csn_low;

    assign div_last = (div_q == DIV_LAST);
    assign div_inc  = div_last ? 8'd0 : div_q + 8'd1;
    assign nxt_idx  = idx_q + 3'd1;
    assign hdr_len  = rd_q ? HDR_RD_BYTES : HDR_WR_BYTES;
    assign rx_smp   = {rx_q[6:0], i_miso};
    assign csn_low  = state_q inside {ST_SETUP, ST_SHIFT, ST_WAIT_DATA, ST_HOLD};

    assign o_busy   = (state_q != ST_IDLE);
    assign o_csn    = ~csn_low;
    assign o_sclk   = sclk_q;
    assign o_mosi   = csn_low & sh_q[7];
    assign o_wready = wready_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;
    assign o_done   = done_q;

    // Frame sequencing: sclk phases, byte boundaries and stalls.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rem_d    = rem_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        rdata_d  = rdata_q;
        wready_d = 1'b0;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                div_d  = 8'd0;
                if (i_start) begin
                    state_d = ST_SETUP;
                    rd_d    = i_rd;
                    addr_d  = i_addr;
                    rem_d   = i_len;
                    sh_d    = hdr_byte(i_rd, i_addr, 3'd0);
                    idx_d   = 3'd0;
                    data_d  = 1'b0;
                    bit_d   = 3'd0;
                    rx_d    = 8'h00;
                end
            end
            ST_SETUP: begin
                div_d = div_inc;
                if (div_last) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = rx_smp;
                end
            end
            ST_SHIFT: begin
                div_d = div_inc;
                if (div_last && !sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = rx_smp;
                    if (bit_q == 3'd7 && data_q && rd_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = rx_smp;
                    end
                end else if (div_last) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 3'd1;
                    sh_d   = {sh_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        if (!data_q && nxt_idx < hdr_len) begin
                            idx_d = nxt_idx;
                            sh_d  = hdr_byte(rd_q, addr_q, nxt_idx);
                        end else if (rem_q != '0) begin
                            data_d = 1'b1;
                            rem_d  = rem_q - LEN_ONE;
                            if (rd_q) begin
                                sh_d = 8'h00;
                            end else if (i_wvalid) begin
                                sh_d     = i_wdata;
                                wready_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_DATA;
                            end
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_WAIT_DATA: begin
                div_d  = 8'd0;
                sclk_d = 1'b0;
                if (i_wvalid) begin
                    sh_d     = i_wdata;
                    wready_d = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                div_d = div_inc;
                if (div_last) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                div_d = div_inc;
                if (div_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= 8'd0;
            bit_q    <= 3'd0;
            idx_q    <= 3'd0;
            data_q   <= 1'b0;
            rem_q    <= '0;
            rd_q     <= 1'b0;
            addr_q   <= 32'h0;
            sh_q     <= 8'h00;
            rx_q     <= 8'h00;
            sclk_q   <= 1'b0;
            rdata_q  <= 8'h00;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            rdata_q  <= rdata_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

endmodule
